// File: rtl/alu_pkg.sv
// Shared types and constants for the alu and the blocks that feed it.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_NOT = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6
  } aluop_t;

  localparam logic [2:0] ALU_OP_ILLEGAL = 3'd7;
  localparam int         ALU_LAT        = 2;
  localparam int         RESP_ID_W      = 4;

  typedef struct packed {
    logic [31:0]          f;
    logic [RESP_ID_W-1:0] id;
    logic                 err;
  } resp_t;

  // The illegal opcode still occupies an alu slot so ordering is kept; send a harmless and.
  function automatic aluop_t issue_op(input logic [2:0] op);
    if (op == ALU_OP_ILLEGAL) begin
      return ALU_AND;
    end else begin
      return aluop_t'(op);
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head, full/empty flags; writes while full are dropped
// unless a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_s;
  logic             do_rd_s, do_wr_s;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);
  assign rd_data = mem_r[rd_ptr_r];

  // Next occupancy from this cycle's read/write.
  always_comb begin
    count_s = count_r;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_wr_s) wr_ptr_r <= bump(wr_ptr_r);
      if (do_rd_s) rd_ptr_r <= bump(rd_ptr_r);
      count_r <= count_s;
      full    <= (count_s == CNT_W'(DEPTH));
      empty   <= (count_s == CNT_W'(0));
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_wr_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/collect stage for the 2-cycle alu: credit-gated accept, tag pipe aligned with the
// alu latency, and an in-order result FIFO toward the consumer.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [ID_W-1:0] req_id,
  output logic [2:0]      alu_aluop,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic            alu_valid_i,
  input  logic [31:0]     alu_f,
  input  logic            alu_valid_o,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_f,
  output logic [ID_W-1:0] resp_id,
  output logic            resp_err,
  output logic            proto_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int FW    = 32 + ID_W + 1;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  tag_t             tag0_r, tag1_r, tag2_r;
  logic [CNT_W-1:0] credit_r;
  logic [1:0]       drain_r;
  logic             issue_v_r;
  logic             drain_s, accept_s, pop_s, collect_s, rd_s, overflow_s;
  logic [FW-1:0]    fifo_wdata_s, fifo_rdata_s;
  logic             fifo_full_s, fifo_empty_s;

  assign drain_s      = (drain_r != 2'd0);
  assign req_ready    = !rst && !drain_s && (credit_r < CNT_W'(DEPTH));
  assign accept_s     = req_valid && req_ready;
  assign pop_s        = resp_valid && resp_ready;
  assign alu_valid_i  = issue_v_r && !rst;
  assign collect_s    = alu_valid_o && tag2_r.v && !drain_s && !rst;
  assign rd_s         = resp_ready && !fifo_empty_s;
  assign overflow_s   = collect_s && fifo_full_s && !rd_s;
  assign fifo_wdata_s = {(tag2_r.err ? 32'd0 : alu_f), tag2_r.id, tag2_r.err};
  assign resp_valid   = !fifo_empty_s;
  assign {resp_f, resp_id, resp_err} = fifo_rdata_s;

  // The alu pipe has no reset; ignore its outputs for ALU_LAT cycles after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_r <= 2'(ALU_LAT);
    end else if (drain_s) begin
      drain_r <= drain_r - 2'd1;
    end else begin
      drain_r <= drain_r;
    end
  end

  // Credit = ops accepted but not yet handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   credit_r <= credit_r + CNT_W'(1);
        2'b01:   credit_r <= credit_r - CNT_W'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Issue registers driving the alu inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_v_r <= 1'b0;
      alu_aluop <= 3'd0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
    end else begin
      issue_v_r <= accept_s;
      if (accept_s) begin
        alu_aluop <= issue_op(req_op);
        alu_a     <= req_a;
        alu_b     <= req_b;
      end
    end
  end

  // Tag pipe: stage 2 lines up with alu_valid_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag0_r <= '0;
      tag1_r <= '0;
      tag2_r <= '0;
    end else begin
      tag0_r <= '{v: accept_s, id: req_id, err: (req_op == ALU_OP_ILLEGAL)};
      tag1_r <= tag0_r;
      tag2_r <= tag1_r;
    end
  end

  // Sticky protocol error: stray/missing alu result or overflowing write.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (!drain_s && ((alu_valid_o != tag2_r.v) || overflow_s)) begin
      proto_err <= 1'b1;
    end else begin
      proto_err <= proto_err;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (collect_s),
    .wr_data (fifo_wdata_s),
    .rd_en   (resp_ready),
    .rd_data (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural 2-cycle alu stand-in and a queue-based model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 8;
  localparam int ID_W  = 4;

  logic            clk = 1'b0;
  logic            rst, req_valid, req_ready;
  logic [2:0]      req_op, alu_aluop;
  logic [31:0]     req_a, req_b, alu_a, alu_b, alu_f, resp_f;
  logic [ID_W-1:0] req_id, resp_id;
  logic            alu_valid_i, alu_valid_o, resp_valid, resp_ready, resp_err, proto_err;

  always #5 clk = ~clk;

  alu_sequencer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_id(req_id), .alu_aluop(alu_aluop), .alu_a(alu_a),
    .alu_b(alu_b), .alu_valid_i(alu_valid_i), .alu_f(alu_f), .alu_valid_o(alu_valid_o),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_f(resp_f), .resp_id(resp_id),
    .resp_err(resp_err), .proto_err(proto_err)
  );

  function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic resp_t ref_resp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [ID_W-1:0] id);
    resp_t r;
    r.id  = id;
    r.err = (op == 3'd7);
    r.f   = r.err ? 32'd0 : alu_calc(op, a, b);
    return r;
  endfunction

  // Alu stand-in: two register stages, no reset; force_v injects a stray result.
  logic        p1_v, p2_v, force_v;
  logic [31:0] p1_f, p2_f;
  always @(posedge clk) begin
    p1_v <= alu_valid_i;
    p1_f <= alu_calc(alu_aluop, alu_a, alu_b);
    p2_v <= p1_v;
    p2_f <= p1_f;
  end
  assign alu_valid_o = p2_v | force_v;
  assign alu_f       = p2_f;

  int    n_checks = 0;
  int    n_fail   = 0;
  resp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: record accepts, compare every consumed response in order.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'd1, 64'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("resp_order", {27'd0, resp_f, resp_id, resp_err}, {27'd0, e});
        end
      end
      if (req_valid && req_ready) exp_q.push_back(ref_resp(req_op, req_a, req_b, req_id));
    end
  end

  typedef struct {
    logic [2:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [ID_W-1:0] id;
    logic [31:0]     f;
    logic            err;
  } vec_t;

  vec_t vecs[10];
  vec_t t4[3];
  int   idx[8] = '{5, 7, 8, 3, 0, 1, 2, 9};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_id    = v.id;
    req_valid = 1'b1;
  endtask

  task automatic run_single(input vec_t v, input string name);
    int g;
    int lat;
    drive(v);
    g = 0;
    while (!req_ready && g < 20) begin tick(); g++; end
    check({name, "_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin tick(); lat++; end
    check({name, "_latency"}, lat, 4);
    check({name, "_f"}, resp_f, v.f);
    check({name, "_id"}, resp_id, v.id);
    check({name, "_err"}, resp_err, v.err);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || resp_valid) && g < max_cycles) begin tick(); g++; end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int seen;
    int bad;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0; req_id = '0;
    resp_ready = 1'b0; force_v = 1'b0;
    vecs[0] = '{3'd3, 32'd5,          32'd7,          4'd3,  32'd12,         1'b0};
    vecs[1] = '{3'd0, 32'hF0F0_1234,  32'h0FF0_FFFF,  4'd1,  32'h00F0_1234,  1'b0};
    vecs[2] = '{3'd1, 32'hF000_0000,  32'h0000_000F,  4'd2,  32'hF000_000F,  1'b0};
    vecs[3] = '{3'd2, 32'd0,          32'h0000_1234,  4'd4,  32'hFFFF_FFFF,  1'b0};
    vecs[4] = '{3'd3, 32'hFFFF_FFFF,  32'd1,          4'd5,  32'd0,          1'b0};
    vecs[5] = '{3'd4, 32'd10,         32'd3,          4'd6,  32'd7,          1'b0};
    vecs[6] = '{3'd4, 32'd0,          32'd1,          4'd7,  32'hFFFF_FFFF,  1'b0};
    vecs[7] = '{3'd5, 32'd1,          32'd31,         4'd8,  32'h8000_0000,  1'b0};
    vecs[8] = '{3'd6, 32'h8000_0000,  32'd31,         4'd9,  32'd1,          1'b0};
    vecs[9] = '{3'd7, 32'd123,        32'd456,        4'd15, 32'd0,          1'b1};
    t4[0]   = '{3'd3, 32'd1,          32'd2,          4'd1,  32'd3,          1'b0};
    t4[1]   = '{3'd7, 32'd77,         32'd88,         4'd9,  32'd0,          1'b1};
    t4[2]   = '{3'd3, 32'd3,          32'd4,          4'd2,  32'd7,          1'b0};

    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_valid_i", alu_valid_i, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_alu_regs", {alu_aluop, alu_a, alu_b}, 0);
    rst = 1'b0;
    check("drain_ready_c0", req_ready, 0);
    tick();
    check("drain_ready_c1", req_ready, 0);
    tick();
    check("ready_after_drain", req_ready, 1);

    // Single ops, one at a time, latency and value per table entry.
    for (int i = 0; i < 10; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back at full rate.
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(vecs[idx[k]]);
      check($sformatf("b2b_ready%0d", k), req_ready, 1);
      tick();
    end
    req_valid = 1'b0;
    wait_empty("b2b_drain", 30);

    // Fill to credit limit with the consumer stalled.
    resp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      drive(vecs[k]);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    check("fill_accepts", acc, DEPTH);
    repeat (4) tick();
    check("fill_ready_low", req_ready, 0);
    check("fill_resp_valid", resp_valid, 1);
    resp_ready = 1'b1;
    check("pop_cycle_ready", req_ready, 0);
    tick();
    check("ready_after_pop", req_ready, 1);
    wait_empty("fill_drain", 30);

    // Illegal op between two adds.
    for (int k = 0; k < 3; k++) begin drive(t4[k]); tick(); end
    req_valid = 1'b0;
    wait_empty("illegal_drain", 30);
    check("illegal_proto", proto_err, 0);

    // Reset with results in the FIFO and ops in the alu.
    resp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin drive(vecs[k]); tick(); end
    req_valid = 1'b0;
    repeat (5) tick();
    check("pre_rst_fifo", resp_valid, 1);
    for (int k = 2; k < 5; k++) begin
      drive(vecs[k]);
      check($sformatf("pre_rst_ready%0d", k), req_ready, 1);
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_resp", resp_valid, 0);
    resp_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      if (resp_valid || proto_err) seen = 1;
      tick();
    end
    check("drain_stale", seen, 0);
    resp_ready = 1'b0;
    run_single(vecs[7], "post_rst");
    check("post_rst_proto", proto_err, 0);

    // Stray alu result with nothing in flight.
    repeat (3) tick();
    force_v = 1'b1;
    tick();
    force_v = 1'b0;
    check("proto_set", proto_err, 1);
    check("proto_no_write", resp_valid, 0);
    repeat (5) tick();
    check("proto_sticky", proto_err, 1);
    check("proto_no_write_later", resp_valid, 0);
    rst = 1'b1;
    repeat (2) tick();
    check("proto_cleared", proto_err, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Random traffic against the queue model; ready must track outstanding count.
    bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid  = ($urandom_range(3) != 0);
      req_op     = 3'($urandom_range(7));
      req_a      = $urandom;
      req_b      = ($urandom_range(1) != 0) ? 32'($urandom_range(31)) : $urandom;
      req_id     = ID_W'($urandom_range(15));
      resp_ready = ((cyc % 64) < 20) ? 1'b0 : ($urandom_range(2) != 0);
      if (req_ready !== (exp_q.size() < DEPTH)) bad++;
      tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check("ready_vs_outstanding", bad, 0);
    wait_empty("random_drain", 60);
    check("random_proto", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
